// File: rtl/dma_engine.sv
// dma_engine: single-channel word-copy DMA. A register responder port programs
// SRC/DST/LEN/CTRL; an initiator port with ready wait states performs the copy.
module dma_engine #(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_write_data,
    input  logic        s_write_en,
    input  logic        s_read_en,
    output logic [31:0] s_read_data,
    output logic [31:0] m_addr,
    output logic [31:0] m_write_data,
    output logic        m_read_en,
    output logic        m_write_en,
    input  logic [31:0] m_read_data,
    input  logic        m_ready,
    output logic        irq
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR_REQ  = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_src, r_dst, r_cur_src, r_cur_dst, r_data;
    logic [LEN_WIDTH-1:0] r_len, r_rem;
    logic                 r_irq_en, r_done, r_err;
    logic [31:0]          r_s_rdata, r_m_addr, r_m_wdata;
    logic                 r_m_rd_en, r_m_wr_en, r_irq;

    logic [2:0]           w_idx;
    logic                 w_idle, w_wr_src, w_wr_dst, w_wr_len, w_wr_ctrl, w_wr_stat;
    logic                 w_start, w_misalign, w_go, w_xfer_done;
    logic [31:0]          w_cur_src_nxt, w_cur_dst_nxt, w_data_nxt;
    logic [31:0]          w_rd_mux, w_m_addr_nxt, w_m_wdata_nxt;
    logic [LEN_WIDTH-1:0] w_rem_nxt;
    logic                 w_done_nxt, w_err_nxt, w_irq_en_nxt;
    logic                 w_unused;

    assign w_idx      = s_addr[4:2];
    assign w_idle     = (r_state == ST_IDLE);
    // Programming registers are frozen while a copy is running.
    assign w_wr_src   = s_write_en && (w_idx == 3'd0) && w_idle;
    assign w_wr_dst   = s_write_en && (w_idx == 3'd1) && w_idle;
    assign w_wr_len   = s_write_en && (w_idx == 3'd2) && w_idle;
    assign w_wr_ctrl  = s_write_en && (w_idx == 3'd3);
    assign w_wr_stat  = s_write_en && (w_idx == 3'd4);
    assign w_start    = w_wr_ctrl && s_write_data[0] && w_idle;
    assign w_misalign = (r_src[1:0] != 2'b00) || (r_dst[1:0] != 2'b00);
    assign w_go       = w_start && !w_misalign && (r_len != LEN_ZERO);
    assign w_unused   = &{1'b0, s_addr[31:5], s_addr[1:0]};

    assign s_read_data  = r_s_rdata;
    assign m_addr       = r_m_addr;
    assign m_write_data = r_m_wdata;
    assign m_read_en    = r_m_rd_en;
    assign m_write_en   = r_m_wr_en;
    assign irq          = r_irq;

    // Copy FSM next-state and working-copy updates.
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_src_nxt = r_cur_src;
        w_cur_dst_nxt = r_cur_dst;
        w_rem_nxt     = r_rem;
        w_data_nxt    = r_data;
        w_xfer_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt   = ST_RD_REQ;
                    w_cur_src_nxt = r_src;
                    w_cur_dst_nxt = r_dst;
                    w_rem_nxt     = r_len;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (m_ready) begin
                    w_state_nxt = ST_RD_DATA;
                end else begin
                    w_state_nxt = ST_RD_REQ;
                end
            end
            ST_RD_DATA: begin
                w_data_nxt  = m_read_data;
                w_state_nxt = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (m_ready) begin
                    w_cur_src_nxt = r_cur_src + 32'd4;
                    w_cur_dst_nxt = r_cur_dst + 32'd4;
                    w_rem_nxt     = r_rem - LEN_ONE;
                    if (r_rem == LEN_ONE) begin
                        w_state_nxt = ST_IDLE;
                        w_xfer_done = 1'b1;
                    end else begin
                        w_state_nxt = ST_RD_REQ;
                    end
                end else begin
                    w_state_nxt = ST_WR_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Initiator outputs are registered, so they are computed from next state.
    always_comb begin
        w_m_addr_nxt  = 32'h0000_0000;
        w_m_wdata_nxt = 32'h0000_0000;
        case (w_state_nxt)
            ST_RD_REQ: begin
                w_m_addr_nxt = w_cur_src_nxt;
            end
            ST_WR_REQ: begin
                w_m_addr_nxt  = w_cur_dst_nxt;
                w_m_wdata_nxt = w_data_nxt;
            end
            default: begin
                w_m_addr_nxt  = 32'h0000_0000;
                w_m_wdata_nxt = 32'h0000_0000;
            end
        endcase
    end

    // Status flags: a set in the same cycle as a clear wins.
    always_comb begin
        if (w_xfer_done || (w_start && !w_misalign && (r_len == LEN_ZERO))) begin
            w_done_nxt = 1'b1;
        end else if (w_start || (w_wr_stat && s_write_data[1])) begin
            w_done_nxt = 1'b0;
        end else begin
            w_done_nxt = r_done;
        end
        if (w_start && w_misalign) begin
            w_err_nxt = 1'b1;
        end else if (w_start || (w_wr_stat && s_write_data[2])) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
        if (w_wr_ctrl) begin
            w_irq_en_nxt = s_write_data[1];
        end else begin
            w_irq_en_nxt = r_irq_en;
        end
    end

    // Register-port read decode.
    always_comb begin
        w_rd_mux = 32'h0000_0000;
        case (w_idx)
            3'd0:    w_rd_mux = r_src;
            3'd1:    w_rd_mux = r_dst;
            3'd2:    w_rd_mux = 32'(r_len);
            3'd3:    w_rd_mux = {30'h0, r_irq_en, 1'b0};
            3'd4:    w_rd_mux = {29'h0, r_err, r_done, !w_idle};
            default: w_rd_mux = 32'h0000_0000;
        endcase
    end

    // All state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_src     <= 32'h0000_0000;
            r_dst     <= 32'h0000_0000;
            r_len     <= LEN_ZERO;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cur_src <= 32'h0000_0000;
            r_cur_dst <= 32'h0000_0000;
            r_rem     <= LEN_ZERO;
            r_data    <= 32'h0000_0000;
            r_s_rdata <= 32'h0000_0000;
            r_m_addr  <= 32'h0000_0000;
            r_m_wdata <= 32'h0000_0000;
            r_m_rd_en <= 1'b0;
            r_m_wr_en <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_src <= w_cur_src_nxt;
            r_cur_dst <= w_cur_dst_nxt;
            r_rem     <= w_rem_nxt;
            r_data    <= w_data_nxt;
            if (w_wr_src) r_src <= s_write_data;
            if (w_wr_dst) r_dst <= s_write_data;
            if (w_wr_len) r_len <= s_write_data[LEN_WIDTH-1:0];
            r_irq_en  <= w_irq_en_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            if (s_read_en) r_s_rdata <= w_rd_mux;
            r_m_addr  <= w_m_addr_nxt;
            r_m_wdata <= w_m_wdata_nxt;
            r_m_rd_en <= (w_state_nxt == ST_RD_REQ);
            r_m_wr_en <= (w_state_nxt == ST_WR_REQ);
            r_irq     <= w_done_nxt & w_irq_en_nxt;
        end
    end
endmodule

// File: tb/tb_dma_engine.sv
// Bench for dma_engine: a stalling memory responder checks every bus transaction
// against a transfer-level copy model; the register port is polled for status.
module tb_dma_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_addr, s_write_data, s_read_data;
    logic        s_write_en, s_read_en;
    logic [31:0] m_addr, m_write_data;
    logic [31:0] m_read_data = 32'h0;
    logic        m_ready = 1'b0;
    logic        m_read_en, m_write_en, irq;

    int total = 0;
    int bad = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] q_ra [$];
    logic [31:0] q_wa [$];
    logic [31:0] q_wd [$];
    logic [31:0] rd_log [$];
    int stall_mode = 0;
    int stall_fixed = 0;
    int stall_cnt = 0;
    bit in_req = 1'b0;
    bit rd_pending = 1'b0;
    bit cap_rd = 1'b0;
    int stall_left = 0;
    logic [31:0] cap_addr = 32'h0, cap_data = 32'h0, rd_addr = 32'h0;

    dma_engine #(.LEN_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_addr(s_addr), .s_write_data(s_write_data), .s_write_en(s_write_en),
        .s_read_en(s_read_en), .s_read_data(s_read_data),
        .m_addr(m_addr), .m_write_data(m_write_data), .m_read_en(m_read_en),
        .m_write_en(m_write_en), .m_read_data(m_read_data), .m_ready(m_ready),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    // Memory responder: random/fixed stalls, checks each accepted request.
    always @(negedge clk) begin
        logic [31:0] ea, ed;
        m_read_data = rd_pending ? mem_rd(rd_addr) : $urandom;
        rd_pending = 1'b0;
        if (!rst_n) begin
            in_req  = 1'b0;
            m_ready = 1'b0;
        end else if (m_read_en || m_write_en) begin
            chk1("en_exclusive", m_read_en & m_write_en, 1'b0);
            if (!in_req) begin
                in_req   = 1'b1;
                cap_addr = m_addr;
                cap_data = m_write_data;
                cap_rd   = m_read_en;
                stall_left = (stall_mode == 0) ? 0 :
                             (stall_mode == 1) ? int'($urandom_range(0, 3)) : stall_fixed;
            end else begin
                chk("stall_addr", m_addr, cap_addr);
                chk1("stall_kind", m_read_en, cap_rd);
                if (!cap_rd) chk("stall_wdata", m_write_data, cap_data);
            end
            if (stall_left > 0) begin
                stall_left--;
                stall_cnt++;
                m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
                in_req  = 1'b0;
                if (m_read_en) begin
                    rd_log.push_back(m_addr);
                    ea = (q_ra.size() > 0) ? q_ra.pop_front() : ~m_addr;
                    chk("rd_addr", m_addr, ea);
                    rd_pending = 1'b1;
                    rd_addr    = m_addr;
                end else begin
                    ea = (q_wa.size() > 0) ? q_wa.pop_front() : ~m_addr;
                    ed = (q_wd.size() > 0) ? q_wd.pop_front() : ~m_write_data;
                    chk("wr_addr", m_addr, ea);
                    chk("wr_data", m_write_data, ed);
                    mem[m_addr] = m_write_data;
                end
            end
        end else begin
            in_req  = 1'b0;
            m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        s_addr = a; s_write_data = d; s_write_en = 1'b1; s_read_en = 1'b0;
        @(negedge clk);
        s_write_en = 1'b0;
    endtask

    task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        s_addr = a; s_read_en = 1'b1; s_write_en = 1'b0;
        @(negedge clk);
        s_read_en = 1'b0;
        d = s_read_data;
    endtask

    // Word-by-word copy semantics: expected bus sequence and final memory image.
    task automatic model_xfer(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] d;
        for (int k = 0; k < len; k++) begin
            q_ra.push_back(src + 32'(4 * k));
            q_wa.push_back(dst + 32'(4 * k));
            d = model_rd(src + 32'(4 * k));
            q_wd.push_back(d);
            model_mem[dst + 32'(4 * k)] = d;
        end
    endtask

    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input logic ien, input bit meddle, output int busy_cnt);
        logic [31:0] st, v;
        logic exp_err, exp_done, exp_bus, irq_prev;
        bit fin, prev;
        int stall_base, rd_base;
        exp_err  = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
        exp_done = !exp_err;
        exp_bus  = !exp_err && (len > 0);
        reg_wr(32'h0, src);
        reg_wr(32'h4, dst);
        reg_wr(32'h8, 32'(len));
        if (exp_bus) model_xfer(src, dst, len);
        stall_base = stall_cnt;
        rd_base    = rd_log.size();
        busy_cnt = 0; fin = 1'b0; prev = 1'b0; irq_prev = 1'b0;
        @(negedge clk);
        s_addr = 32'hC; s_write_data = {30'h0, ien, 1'b1}; s_write_en = 1'b1; s_read_en = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            if (c == 0) chk1("rd_en_after_start", m_read_en, exp_bus);
            if (prev) begin
                st = s_read_data;
                if (st[0]) busy_cnt++;
                else fin = 1'b1;
                chk1("status_done", st[1], !st[0] && exp_done);
                chk1("status_err", st[2], exp_err);
                chk1("irq_level", irq_prev, ien && !st[0] && exp_done);
            end
            if (fin) begin
                s_read_en = 1'b0; s_write_en = 1'b0;
            end else if (meddle && c == 4) begin
                s_addr = 32'h8; s_write_data = 32'd9; s_write_en = 1'b1; s_read_en = 1'b0; prev = 1'b0;
            end else if (meddle && c == 6) begin
                s_addr = 32'h0; s_write_data = 32'h1234; s_write_en = 1'b1; s_read_en = 1'b0; prev = 1'b0;
            end else if (meddle && c == 8) begin
                s_addr = 32'hC; s_write_data = {30'h0, ien, 1'b1}; s_write_en = 1'b1; s_read_en = 1'b0; prev = 1'b0;
            end else begin
                s_addr = 32'h10; s_read_en = 1'b1; s_write_en = 1'b0; prev = 1'b1; irq_prev = irq;
            end
        end
        chk1("xfer_finished", fin, 1'b1);
        if (!meddle) chk("busy_cycles", busy_cnt, exp_bus ? 3 * len + (stall_cnt - stall_base) : 0);
        chk("bus_left", q_ra.size() + q_wa.size(), 0);
        if (!exp_bus) chk("no_bus_reads", rd_log.size() - rd_base, 0);
        for (int k = 0; k < len; k++)
            chk("dst_word", mem_rd(dst + 32'(4 * k)), model_rd(dst + 32'(4 * k)));
        reg_rd(32'h0, v); chk("src_readback", v, src);
        reg_rd(32'h8, v); chk("len_readback", v, 32'(len));
    endtask

    initial begin
        logic [31:0] v, src, dst;
        int b, len;
        bit got;
        rst_n = 1'b0;
        s_addr = 32'h0; s_write_data = 32'h0; s_write_en = 1'b0; s_read_en = 1'b0;
        #12;
        chk1("rst_rd_en", m_read_en, 1'b0);
        chk1("rst_wr_en", m_write_en, 1'b0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_write_data, 32'h0);
        chk("rst_s_rdata", s_read_data, 32'h0);
        chk1("rst_irq", irq, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            reg_rd(32'(4 * i), v);
            chk("rst_reg", v, 32'h0);
        end

        // Aligned copy with literal source pattern.
        for (int k = 0; k < 4; k++) begin
            mem[32'h0001_0000 + 32'(4 * k)]       = 32'h1111_1111 * 32'(k + 1);
            model_mem[32'h0001_0000 + 32'(4 * k)] = 32'h1111_1111 * 32'(k + 1);
        end
        run_xfer(32'h0001_0000, 32'h0001_0100, 4, 1'b0, 1'b0, b);
        chk("aligned_busy", b, 12);
        for (int k = 0; k < 4; k++)
            chk("aligned_word", mem_rd(32'h0001_0100 + 32'(4 * k)), 32'h1111_1111 * 32'(k + 1));

        // Two wait states on every request.
        stall_mode = 2; stall_fixed = 2;
        run_xfer(32'h0001_0000, 32'h0001_0200, 2, 1'b0, 1'b0, b);
        chk("wait_busy", b, 14);
        chk("wait_word1", mem_rd(32'h0001_0204), 32'h2222_2222);

        // Zero length and misaligned source.
        stall_mode = 0;
        run_xfer(32'h0001_0000, 32'h0001_0300, 0, 1'b1, 1'b0, b);
        chk("len0_busy", b, 0);
        run_xfer(32'h0001_0002, 32'h0001_0300, 3, 1'b0, 1'b0, b);
        reg_rd(32'h10, v); chk("misalign_status", v, 32'h4);

        // Unmapped offset, read hold, CTRL readback.
        reg_wr(32'h14, 32'hFFFF_FFFF);
        reg_rd(32'h14, v); chk("unmapped_rd", v, 32'h0);
        reg_rd(32'h0, v);
        repeat (3) @(negedge clk);
        chk("rdata_hold", s_read_data, 32'h0001_0002);
        reg_wr(32'hC, 32'h2);
        reg_rd(32'hC, v); chk("ctrl_rd", v, 32'h2);
        reg_wr(32'hC, 32'h0);

        // Register writes and START while busy are ignored.
        stall_mode = 1;
        run_xfer(32'h0001_0000, 32'h0001_0400, 4, 1'b0, 1'b1, b);

        // Interrupt and its clear.
        stall_mode = 0;
        run_xfer(32'h0001_0000, 32'h0001_0500, 1, 1'b1, 1'b0, b);
        chk1("irq_after_done", irq, 1'b1);
        reg_wr(32'h10, 32'h2);
        chk1("irq_after_clear", irq, 1'b0);
        reg_rd(32'h10, v); chk("status_cleared", v, 32'h0);

        // DONE clear in the same cycle as completion: set wins.
        reg_wr(32'h0, 32'h0001_0000); reg_wr(32'h4, 32'h0001_0600); reg_wr(32'h8, 32'd1);
        model_xfer(32'h0001_0000, 32'h0001_0600, 1);
        reg_wr(32'hC, 32'h3);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (m_write_en) begin
                got = 1'b1;
                s_addr = 32'h10; s_write_data = 32'h2; s_write_en = 1'b1;
            end
        end
        chk1("coinc_write_seen", got, 1'b1);
        @(negedge clk); s_write_en = 1'b0;
        chk1("coinc_irq", irq, 1'b1);
        reg_rd(32'h10, v); chk("coinc_status", v, 32'h2);

        // Randomized copies with random stalls.
        stall_mode = 1;
        for (int i = 0; i < 6; i++) begin
            src = 32'h0002_0000 + ($urandom_range(0, 63) << 2);
            dst = 32'h0003_0000 + ($urandom_range(0, 63) << 2);
            len = int'($urandom_range(1, 7));
            run_xfer(src, dst, len, 1'($urandom_range(0, 1)), 1'b0, b);
        end

        // Reset during a stalled WR_REQ.
        stall_mode = 2; stall_fixed = 4;
        reg_wr(32'h0, 32'h0001_0000); reg_wr(32'h4, 32'h0001_0700); reg_wr(32'h8, 32'd3);
        model_xfer(32'h0001_0000, 32'h0001_0700, 3);
        reg_wr(32'hC, 32'h3);
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (m_write_en) got = 1'b1;
        end
        chk1("rst_wr_seen", got, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_rd_en", m_read_en, 1'b0);
        chk1("async_wr_en", m_write_en, 1'b0);
        chk("async_m_addr", m_addr, 32'h0);
        q_ra.delete(); q_wa.delete(); q_wd.delete();
        model_mem = mem;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_rdata", s_read_data, 32'h0);
        for (int i = 0; i < 5; i++) begin
            reg_rd(32'(4 * i), v);
            chk("post_rst_reg", v, 32'h0);
        end

        // Source address wraps through zero.
        stall_mode = 0;
        b = rd_log.size();
        run_xfer(32'hFFFF_FFFC, 32'h0001_0800, 2, 1'b0, 1'b0, len);
        chk("wrap_reads", rd_log.size() - b, 2);
        if (rd_log.size() >= b + 2) begin
            chk("wrap_rd0", rd_log[b], 32'hFFFF_FFFC);
            chk("wrap_rd1", rd_log[b + 1], 32'h0000_0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_engine.md
# dma_engine

Single-channel memory-to-memory word-copy engine for the SoC data bus. Software programs it through a memory-mapped register port, which responds like a UART or GPIO peripheral and decodes the low address bits. It then runs copies through its own initiator port, which uses the same addr/data/enable/ready handshake the CPU drives, and which the bus fabric arbitrates. It is the bus-master counterpart to the existing responder-only peripherals, and it is the first initiator that must honour `ready` wait states.

## Interface
- `LEN_WIDTH`, default 16: width of the transfer word count; maximum transfer is 2^LEN_WIDTH−1 words.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_addr`  in  32  register-port address; only bits [4:2] are decoded.
- `s_write_data`  in  32  register write data.
- `s_write_en`  in  1  register write strobe; already qualified by the fabric's select.
- `s_read_en`  in  1  register read strobe; already qualified by the fabric's select.
- `s_read_data`  out  32  register read data; registered, valid the cycle after `s_read_en`.
- `m_addr`  out  32  initiator address.
- `m_write_data`  out  32  initiator write data.
- `m_read_en`  out  1  initiator read request.
- `m_write_en`  out  1  initiator write request.
- `m_read_data`  in  32  initiator read data; valid the cycle after read acceptance.
- `m_ready`  in  1  responder ready; a request is accepted in any cycle where the request enable and `m_ready` are both high.
- `irq`  out  1  level interrupt, equal to `done & IRQ_EN`.

## Operation
- Register map (byte offset):
  - 0x00 SRC (R/W, 32).
  - 0x04 DST (R/W, 32).
  - 0x08 LEN (R/W, LEN_WIDTH bits, zero-extended on read).
  - 0x0C CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (R/W).
  - 0x10 STATUS: bit0 BUSY (RO); bit1 DONE (write-1-to-clear); bit2 ERR (write-1-to-clear).
  - Other offsets read 0; writes to them are ignored.
- Writes to SRC, DST, LEN or START while BUSY=1 are ignored. IRQ_EN and the STATUS clears still take effect while busy.
- On START while idle:
  - DONE and ERR are cleared.
  - If SRC[1:0] or DST[1:0] is nonzero, ERR is set, no bus cycle is issued and BUSY stays 0.
  - If LEN=0, DONE is set the next cycle with no bus cycles.
  - Otherwise the working copies cur_src, cur_dst and remaining are loaded from SRC, DST and LEN, and the FSM enters RD_REQ.
- FSM states and transitions:
  - IDLE: the only state with BUSY=0.
  - RD_REQ: `m_read_en`=1, `m_addr`=cur_src. Moves to RD_DATA when `m_ready`=1; otherwise holds with outputs stable.
  - RD_DATA: captures `m_read_data` into the data register; enables low. Always moves to WR_REQ.
  - WR_REQ: `m_write_en`=1, `m_addr`=cur_dst, `m_write_data`=captured word. On acceptance: cur_src += 4, cur_dst += 4, remaining −= 1. Then goes to RD_REQ if remaining (after decrement) is nonzero, otherwise to IDLE with DONE set.
- Address arithmetic is 32-bit modulo; 0xFFFFFFFC + 4 wraps to 0x00000000 with no error.
- SRC, DST and LEN registers are not modified by a transfer; reads return the programmed values.
- `m_read_en` and `m_write_en` are never high in the same cycle.
- Simultaneous events:
  - A DONE set and a DONE write-1-clear in the same cycle: set wins.
  - A START with DONE=1 clears DONE, then the new transfer proceeds.

## Timing
- Reset values: every register 0, FSM in IDLE, all outputs 0 (`m_addr`, `m_write_data`, `s_read_data`, both enables, `irq`).
- Reset asserted mid-transfer: the enables drop asynchronously, the transfer is abandoned and no partial-state status remains.
- START write at edge N: BUSY=1 and `m_read_en`=1 from N+1.
- With `m_ready` held at 1, each word takes 3 cycles (RD_REQ, RD_DATA, WR_REQ).
- A LEN=L transfer shows BUSY for 3L cycles. DONE and `irq` rise in the cycle after the final write is accepted.
- Each cycle of `m_ready`=0 during a request adds exactly one cycle. Address, data and enable stay stable throughout a stall.
- Register reads: data appears on `s_read_data` one cycle after `s_read_en` and holds until the next read.

## Test plan
- Aligned copy: SRC=0x00010000, DST=0x00010100, LEN=4 with source words 0x11111111..0x44444444 -> destination holds the same four words; BUSY high for 12 cycles; DONE=1; SRC still reads 0x00010000.
- Wait states: `m_ready` low for 2 cycles on every request, LEN=2 -> correct data; BUSY for 6+8=14 cycles; address and data stable during every stall.
- Boundary cases:
  - LEN=0 -> DONE=1 next cycle and no enable ever asserted.
  - SRC=0x00010002 -> ERR=1, BUSY never 1.
- Writes while busy: write LEN=9 and START mid-transfer -> ignored; the original transfer completes unchanged and LEN reads its original value.
- Interrupt: IRQ_EN=1, LEN=1 -> `irq`=1 after completion. Writing STATUS=0x2 drops `irq` next cycle. Issue a clear in the same cycle as a completion -> DONE remains 1.
- Reset and wrap: `rst_n`=0 during WR_REQ -> enables 0 immediately and all registers read 0 after release. Then SRC=0xFFFFFFFC, LEN=2 -> second read address is 0x00000000.
